// File: rtl/imem_stream_loader.sv
// Byte-stream program loader and instruction RAM feeding a single-cycle core's fetch port.
// Define IMEM_STREAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_stream_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [31:0]       addr,
    output logic [31:0]       inst,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_W:0]     word_idx_q, word_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
    logic [15:0]         hdr_n_s;
    logic                accept_s;
    logic                mem_we_s;
    logic [31:0]         mem_q [DEPTH_WORDS];
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
                        (state_q == S_CSUM) ||
`endif
                        (state_q == S_DATA);
    assign accept_s     = byte_valid & byte_ready;
    assign hdr_n_s      = {byte_data, count_q[7:0]};
    assign cpu_rst      = (state_q != S_DONE);
    assign load_done    = (state_q == S_DONE);
    assign load_err     = (state_q == S_ERR);
    assign words_loaded = words_loaded_q;

    // Next-state, header/data assembly and RAM write strobe
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        byte_idx_d     = byte_idx_q;
        word_idx_d     = word_idx_q;
        asm_d          = asm_q;
        words_loaded_d = words_loaded_q;
        mem_we_s       = 1'b0;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        xor_d          = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Clearing words_loaded here hides the RAM while it is being overwritten
                if (load_start) begin
                    state_d        = S_HDR0;
                    words_loaded_d = '0;
                    byte_idx_d     = 2'd0;
                    word_idx_d     = '0;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
                    xor_d          = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR0: begin
                if (accept_s) begin
                    count_d[7:0] = byte_data;
                    state_d      = S_HDR1;
                end else begin
                    state_d = S_HDR0;
                end
            end
            S_HDR1: begin
                if (accept_s) begin
                    count_d[15:8] = byte_data;
                    if ((hdr_n_s == 16'd0) || (hdr_n_s > 16'(DEPTH_WORDS))) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_HDR1;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ byte_data;
`endif
                    case (byte_idx_q)
                        2'd0:    asm_d[7:0]   = byte_data;
                        2'd1:    asm_d[15:8]  = byte_data;
                        2'd2:    asm_d[23:16] = byte_data;
                        default: begin
                            mem_we_s   = 1'b1;
                            word_idx_d = word_idx_q + 1'b1;
                            if ((16'(word_idx_q) + 16'd1) == count_q) begin
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
                                state_d        = S_CSUM;
`else
                                state_d        = S_DONE;
                                words_loaded_d = count_q[ADDR_W:0];
`endif
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                    endcase
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_s) begin
                    if (byte_data == xor_q) begin
                        state_d        = S_DONE;
                        words_loaded_d = count_q[ADDR_W:0];
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            count_q        <= 16'd0;
            byte_idx_q     <= 2'd0;
            word_idx_q     <= '0;
            asm_q          <= 24'd0;
            words_loaded_q <= '0;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            xor_q          <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            byte_idx_q     <= byte_idx_d;
            word_idx_q     <= word_idx_d;
            asm_q          <= asm_d;
            words_loaded_q <= words_loaded_d;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            xor_q          <= xor_d;
`endif
        end
    end

    // Instruction RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[word_idx_q[ADDR_W-1:0]] <= {byte_data, asm_q};
        end
    end

    // Combinational fetch, NOP outside the loaded image or on misaligned/out-of-map addresses
    always_comb begin
        inst = NOP_INST;
        if ((addr[31:ADDR_W+2] == '0) && (addr[1:0] == 2'b00) &&
            ({1'b0, addr[ADDR_W+1:2]} < words_loaded_q)) begin
            inst = mem_q[addr[ADDR_W+1:2]];
        end else begin
            inst = NOP_INST;
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized scoreboard bench for imem_stream_loader with an abstract image/fetch model.
module tb_imem_stream_loader;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic [31:0] addr = 32'd0;
    logic [31:0] inst;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    imem_stream_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .addr(addr), .inst(inst),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit done;
        bit err;
        int words;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit [31:0]   model_mem [0:255];
    int          model_words = 0;
    bit [31:0]   img[$];
    bit          gap_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] exp_inst(input bit [31:0] a);
        if ((a % 4 == 0) && ((a / 4) < model_words)) return model_mem[a / 4];
        return NOP;
    endfunction

    task automatic check_fetch(input logic [31:0] a);
        @(negedge clk);
        addr = a;
        #1;
        check($sformatf("fetch@%h", a), inst, exp_inst(a));
    endtask

    // Monitor: each new completion (done or err) is compared with the next expectation
    bit prev_done = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if ((load_done && !prev_done) || (load_err && !prev_err)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_completion: done=%0b err=%0b", load_done, load_err);
                end else begin
                    e = sb.pop_front();
                    check("load_done", {31'd0, load_done}, {31'd0, e.done});
                    check("load_err", {31'd0, load_err}, {31'd0, e.err});
                    check("cpu_rst", {31'd0, cpu_rst}, {31'd0, !e.done});
                    check("words_loaded", {23'd0, words_loaded}, e.words);
                end
            end
            prev_done = load_done;
            prev_err  = load_err;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input bit [7:0] b);
        int t = 0;
        @(negedge clk);
        if (gap_mode) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end else begin
            @(posedge clk);
        end
        #1 byte_valid = 1'b0;
    endtask

    task automatic wait_sb();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL completion_timeout: got pending=%0d expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Streams header + img words (+ checksum); abort_after>=0 stops after that many data bytes
    task automatic run_load(input int n, input bit bad_cs, input bit mid_pulse, input int abort_after);
        bit [7:0] q[$];
        bit [7:0] cs = 8'h00;
        bit [7:0] b;
        bit       ok;
        exp_t     e;
        pulse_start();
        model_words = 0;
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        ok = (n >= 1) && (n <= 256);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b = 8'((img[i] >> (8 * k)) & 32'hFF);
                    q.push_back(b);
                    cs ^= b;
                end
            end
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            q.push_back(bad_cs ? (cs ^ 8'h5A) : cs);
            ok = !bad_cs;
`endif
        end
        if (abort_after < 0) begin
            e.done  = ok;
            e.err   = !ok;
            e.words = ok ? n : 0;
            sb.push_back(e);
        end
        for (int i = 0; i < q.size(); i++) begin
            if (abort_after >= 0 && i == 2 + abort_after) break;
            send_byte(q[i]);
            if (mid_pulse && i == 4) pulse_start();
        end
        if (abort_after < 0) begin
            if (ok) begin
                for (int i = 0; i < n; i++) model_mem[i] = img[i];
                model_words = n;
            end
            wait_sb();
        end
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom());
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_words", {23'd0, words_loaded}, 32'd0);
        check("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
        check("rst_inst", inst, NOP);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_byte_ready", {31'd0, byte_ready}, 32'd0);

        // Two-word reference program
        img = '{32'h00500093, 32'h00A00113};
        run_load(2, 1'b0, 1'b0, -1);
        check("cpu_rst_released", {31'd0, cpu_rst}, 32'd0);
        addr = 32'd0; #1 check("plan_addr0", inst, 32'h00500093);
        addr = 32'd4; #1 check("plan_addr4", inst, 32'h00A00113);
        addr = 32'd8; #1 check("plan_addr8", inst, NOP);
        addr = 32'd2; #1 check("plan_addr2", inst, NOP);

        // Throttled stream with an ignored load_start mid-DATA
        gap_mode = 1'b1;
        run_load(2, 1'b0, 1'b1, -1);
        gap_mode = 1'b0;
        check_fetch(32'd0);
        check_fetch(32'd4);
        check_fetch(32'd8);

        // Rejected headers
        run_load(0, 1'b0, 1'b0, -1);
        check_fetch(32'd0);
        run_load(257, 1'b0, 1'b0, -1);
        check("err_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Reset after five data bytes, then a clean reload
        rand_img(3);
        run_load(3, 1'b0, 1'b0, 5);
        @(negedge clk);
        rst = 1'b1;
        addr = 32'd0;
        #1;
        model_words = 0;
        check("abort_words", {23'd0, words_loaded}, 32'd0);
        check("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("abort_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("abort_inst", inst, NOP);
        @(negedge clk);
        rst = 1'b0;
        run_load(3, 1'b0, 1'b0, -1);
        for (int a = 0; a < 16; a += 4) check_fetch(a);

        // Full-depth image
        rand_img(256);
        run_load(256, 1'b0, 1'b0, -1);
        check_fetch(32'd1020);
        check_fetch(32'd1024);
        check_fetch(32'h80000000);

`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        img = '{32'h00000013};
        run_load(1, 1'b0, 1'b0, -1);
        check_fetch(32'd0);
        run_load(1, 1'b1, 1'b0, -1);
        check("cs_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
`endif

        // Randomized loads and fetches
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 5) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : 257 + $urandom_range(0, 60000);
            else n = $urandom_range(1, 24);
            rand_img((n >= 1 && n <= 256) ? n : 0);
            gap_mode = $urandom_range(0, 1) == 1;
            run_load(n, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, -1);
            gap_mode = 1'b0;
            for (int j = 0; j < 12; j++) begin
                case ($urandom_range(0, 3))
                    0: check_fetch($urandom_range(0, 27) * 4);
                    1: check_fetch($urandom_range(0, 120));
                    2: check_fetch($urandom());
                    default: check_fetch($urandom_range(0, 7) * 4);
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
